// File: rtl/aes_dec_pkg.sv
// Shared definitions for the AES-256 decrypt datapath.
//   AES_BLOCK_W / AES_BYTES : state width in bits / bytes
//   inv_sr_idx(k)           : source byte index feeding output byte k of InvShiftRows
//   sr_idx(k)               : source byte index feeding output byte k of ShiftRows (encrypt side)
// Byte k of a state is bits [k*8 +: 8] of a [0:127] vector, k = row + 4*col.
package aes_dec_pkg;

    localparam int AES_BLOCK_W = 128;
    localparam int AES_BYTES   = 16;

    // Row r rotated right by r: out[r][c] = in[r][(c - r) mod 4] -> (13r + 4c) mod 16.
    function automatic int inv_sr_idx(input int k);
        return (13 * (k % 4) + 4 * (k / 4)) % 16;
    endfunction

    // Row r rotated left by r: out[r][c] = in[r][(c + r) mod 4] -> (5r + 4c) mod 16.
    function automatic int sr_idx(input int k);
        return (5 * (k % 4) + 4 * (k / 4)) % 16;
    endfunction

endpackage

// File: rtl/inv_shift_rows_comb.sv
// Pure combinational InvShiftRows byte permutation.
//   state : input state, column-major byte order
//   perm  : InvShiftRows(state), same byte order
module inv_shift_rows_comb
    import aes_dec_pkg::*;
(
    input  logic [0:AES_BLOCK_W-1] state,
    output logic [0:AES_BLOCK_W-1] perm
);

    for (genvar r = 0; r < 4; r++) begin : g_row
        for (genvar c = 0; c < 4; c++) begin : g_col
            localparam int K   = r + 4 * c;
            localparam int SRC = inv_sr_idx(K);
            assign perm[K*8 +: 8] = state[SRC*8 +: 8];
        end
    end

endmodule

// File: rtl/inv_shift_rows_stage.sv
// Registered InvShiftRows stage with a 2-entry elastic buffer.
//   clk, reset      : clock, async active-low reset
//   flush           : synchronous clear of buffered entries
//   in_ready/in/in_tag : input strobe, state, sideband tag
//   in_busy         : skid entry occupied, upstream must hold
//   out_ready/out/out_tag : output valid, permuted state, tag (direct flop outputs)
//   out_hold        : downstream backpressure
//   level           : entries buffered (0..2)
module inv_shift_rows_stage
    import aes_dec_pkg::*;
#(
    parameter int TAG_W = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   in_ready,
    input  logic [0:AES_BLOCK_W-1] in,
    input  logic [TAG_W-1:0]       in_tag,
    output logic                   in_busy,
    output logic                   out_ready,
    output logic [0:AES_BLOCK_W-1] out,
    output logic [TAG_W-1:0]       out_tag,
    input  logic                   out_hold,
    output logic [1:0]             level
);

    logic [0:AES_BLOCK_W-1] perm;
    logic                   main_vld, skid_vld;
    logic [0:AES_BLOCK_W-1] main_data, skid_data;
    logic [TAG_W-1:0]       main_tag, skid_tag;
    logic                   accept, emit;

    // Permute before storage so the output is a bare register.
    inv_shift_rows_comb u_perm (
        .state (in),
        .perm  (perm)
    );

    // A full skid blocks input, so level 2 never accepts.
    assign accept = in_ready && !skid_vld;
    assign emit   = main_vld && !out_hold;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            main_vld  <= 1'b0;
            skid_vld  <= 1'b0;
            main_data <= '0;
            main_tag  <= '0;
            skid_data <= '0;
            skid_tag  <= '0;
        end else if (flush) begin
            main_vld <= 1'b0;
            skid_vld <= 1'b0;
        end else if (skid_vld) begin
            if (emit) begin
                main_data <= skid_data;
                main_tag  <= skid_tag;
                skid_vld  <= 1'b0;
            end
        end else if (main_vld) begin
            if (accept && emit) begin
                main_data <= perm;
                main_tag  <= in_tag;
            end else if (accept) begin
                skid_data <= perm;
                skid_tag  <= in_tag;
                skid_vld  <= 1'b1;
            end else if (emit) begin
                main_vld <= 1'b0;
            end
        end else if (accept) begin
            main_data <= perm;
            main_tag  <= in_tag;
            main_vld  <= 1'b1;
        end
    end

    assign out_ready = main_vld;
    assign out       = main_data;
    assign out_tag   = main_tag;
    assign in_busy   = skid_vld;
    assign level     = {1'b0, main_vld} + {1'b0, skid_vld};

endmodule

// File: tb/tb_inv_shift_rows_stage.sv
module tb_inv_shift_rows_stage;

    logic         clk;
    logic         reset;
    logic         flush;
    logic         in_ready;
    logic [0:127] in;
    logic [3:0]   in_tag;
    logic         in_busy;
    logic         out_ready;
    logic [0:127] out;
    logic [3:0]   out_tag;
    logic         out_hold;
    logic [1:0]   level;

    int n_cmp = 0;
    int n_err = 0;

    inv_shift_rows_stage #(.TAG_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_ready  (in_ready),
        .in        (in),
        .in_tag    (in_tag),
        .in_busy   (in_busy),
        .out_ready (out_ready),
        .out       (out),
        .out_tag   (out_tag),
        .out_hold  (out_hold),
        .level     (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Encrypt-side ShiftRows: out[r][c] = in[r][(c + r) mod 4].
    function automatic logic [0:127] fsr(input logic [0:127] s);
        logic [0:127] o;
        o = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                o[(r + 4*c)*8 +: 8] = s[(r + 4*((c + r) % 4))*8 +: 8];
        return o;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #3;
        reset = 1'b1;
        step();
    endtask

    task automatic test_reset();
        reset = 1'b0; flush = 0; in_ready = 0; in = '0; in_tag = 0; out_hold = 0;
        #2;
        n_cmp++;
        if (out_ready !== 1'b0 || in_busy !== 1'b0 || level !== 2'd0 || out !== 128'd0 || out_tag !== 4'd0) begin
            n_err++;
            $display("FAIL reset_state: out_ready=%b in_busy=%b level=%0d out=%h tag=%h, want all zero",
                     out_ready, in_busy, level, out, out_tag);
        end
        #2 reset = 1'b1;
        step();
    endtask

    task automatic test_known_vector();
        in = 128'h000102030405060708090a0b0c0d0e0f; in_tag = 4'd3; in_ready = 1;
        step();
        in_ready = 0;
        n_cmp++;
        if (out_ready !== 1'b1 || out !== 128'h000d0a0704010e0b0805020f0c090603 || out_tag !== 4'd3 || level !== 2'd1) begin
            n_err++;
            $display("FAIL known_vector: rdy=%b out=%h tag=%0d level=%0d, want rdy=1 out=000d0a0704010e0b0805020f0c090603 tag=3 level=1",
                     out_ready, out, out_tag, level);
        end
        step();
        n_cmp++;
        if (out_ready !== 1'b0 || level !== 2'd0) begin
            n_err++;
            $display("FAIL known_vector_drain: rdy=%b level=%0d, want 0 0", out_ready, level);
        end
    endtask

    task automatic test_round_trip();
        logic [0:127] exp_q[$];
        logic [3:0]   tag_q[$];
        logic [0:127] st;
        logic [3:0]   tg;
        int sent = 0;
        int cyc  = 0;
        st = {$urandom, $urandom, $urandom, $urandom};
        tg = 4'($urandom_range(0, 15));
        while ((sent < 1000 || exp_q.size() != 0) && cyc < 6000) begin
            out_hold = ($urandom_range(0, 3) == 0);
            in_ready = (sent < 1000) && ($urandom_range(0, 4) != 0);
            in       = fsr(st);
            in_tag   = tg;
            if (out_ready && !out_hold) begin
                n_cmp++;
                if (exp_q.size() == 0 || out !== exp_q[0] || out_tag !== tag_q[0]) begin
                    n_err++;
                    $display("FAIL round_trip: out=%h tag=%0d, want %h tag %0d",
                             out, out_tag, exp_q.size() ? exp_q[0] : 128'd0, tag_q.size() ? tag_q[0] : 4'd0);
                end
                if (exp_q.size() != 0) begin
                    void'(exp_q.pop_front());
                    void'(tag_q.pop_front());
                end
            end
            if (in_ready && !in_busy) begin
                exp_q.push_back(st);
                tag_q.push_back(tg);
                sent++;
                st = {$urandom, $urandom, $urandom, $urandom};
                tg = 4'($urandom_range(0, 15));
            end
            step();
            cyc++;
        end
        in_ready = 0; out_hold = 0;
        n_cmp++;
        if (cyc >= 6000 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL round_trip_timeout: sent=%0d pending=%0d, want 1000 sent and 0 pending", sent, exp_q.size());
        end
        step();
    endtask

    task automatic test_backpressure();
        logic [0:127] a, b, c;
        a = 128'h11111111_22222222_33333333_44444444;
        b = 128'hdeadbeef_01234567_89abcdef_fedcba98;
        c = 128'hcafef00d_cafef00d_cafef00d_cafef00d;
        out_hold = 1;
        in_ready = 1;
        in = fsr(a); in_tag = 4'd1; step();
        in = fsr(b); in_tag = 4'd2; step();
        in = fsr(c); in_tag = 4'd7; step();
        in_ready = 0;
        n_cmp++;
        if (level !== 2'd2 || in_busy !== 1'b1 || out_ready !== 1'b1 || out !== a || out_tag !== 4'd1) begin
            n_err++;
            $display("FAIL bp_full: level=%0d busy=%b out=%h tag=%0d, want 2 1 %h 1", level, in_busy, out, out_tag, a);
        end
        out_hold = 0;
        step();
        n_cmp++;
        if (level !== 2'd1 || in_busy !== 1'b0 || out !== b || out_tag !== 4'd2) begin
            n_err++;
            $display("FAIL bp_second: level=%0d busy=%b out=%h tag=%0d, want 1 0 %h 2", level, in_busy, out, out_tag, b);
        end
        step();
        n_cmp++;
        if (level !== 2'd0 || out_ready !== 1'b0) begin
            n_err++;
            $display("FAIL bp_c_dropped: level=%0d rdy=%b out=%h, want 0 0", level, out_ready, out);
        end
    endtask

    task automatic test_back_to_back();
        logic [0:127] w[8];
        for (int i = 0; i < 8; i++) w[i] = {4{8'(i * 16 + 5), 8'(i + 1), 8'hA0, 8'(255 - i)}};
        out_hold = 0;
        for (int i = 0; i < 8; i++) begin
            in_ready = 1; in = fsr(w[i]); in_tag = 4'(i + 8);
            step();
            n_cmp++;
            if (out_ready !== 1'b1 || out !== w[i] || out_tag !== 4'(i + 8) || level !== 2'd1 || in_busy !== 1'b0) begin
                n_err++;
                $display("FAIL b2b_%0d: out=%h tag=%0d level=%0d busy=%b, want %h %0d 1 0",
                         i, out, out_tag, level, in_busy, w[i], i + 8);
            end
        end
        in_ready = 0;
        step();
        n_cmp++;
        if (level !== 2'd0) begin
            n_err++;
            $display("FAIL b2b_drain: level=%0d, want 0", level);
        end
    endtask

    task automatic test_flush();
        out_hold = 1; in_ready = 1;
        in = fsr(128'h1); in_tag = 4'd4; step();
        in = fsr(128'h2); in_tag = 4'd5; step();
        n_cmp++;
        if (level !== 2'd2) begin
            n_err++;
            $display("FAIL flush_setup: level=%0d, want 2", level);
        end
        flush = 1;
        in = fsr(128'h3); in_tag = 4'd6; step();
        flush = 0; in_ready = 0;
        n_cmp++;
        if (level !== 2'd0 || out_ready !== 1'b0 || in_busy !== 1'b0) begin
            n_err++;
            $display("FAIL flush: level=%0d rdy=%b busy=%b, want 0 0 0", level, out_ready, in_busy);
        end
        out_hold = 0;
        step();
        n_cmp++;
        if (level !== 2'd0 || out_ready !== 1'b0) begin
            n_err++;
            $display("FAIL flush_dropped: level=%0d rdy=%b, want 0 0", level, out_ready);
        end
    endtask

    task automatic test_async_reset();
        logic [0:127] p;
        p = 128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0;
        out_hold = 1; in_ready = 1;
        in = fsr(128'h55); in_tag = 4'd1; step();
        in = fsr(128'h66); in_tag = 4'd2; step();
        in_ready = 0;
        #2 reset = 1'b0;
        #1;
        n_cmp++;
        if (out_ready !== 1'b0 || in_busy !== 1'b0 || level !== 2'd0 || out !== 128'd0) begin
            n_err++;
            $display("FAIL async_reset: rdy=%b busy=%b level=%0d out=%h, want 0 0 0 0", out_ready, in_busy, level, out);
        end
        #1 reset = 1'b1;
        out_hold = 0; in_ready = 1; in = fsr(p); in_tag = 4'd9;
        step();
        in_ready = 0;
        n_cmp++;
        if (out_ready !== 1'b1 || out !== p || out_tag !== 4'd9 || level !== 2'd1) begin
            n_err++;
            $display("FAIL post_reset_word: rdy=%b out=%h tag=%0d level=%0d, want 1 %h 9 1", out_ready, out, out_tag, level, p);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_known_vector();
        test_round_trip();
        test_backpressure();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
